// File: rtl/test_sender.sv
// Purpose : synthetic Ethernet frame source; header then LENGTH counting payload beats per frame.
// Latency : hdr_valid rises one clk after enable is seen in IDLE; back-to-back frames when gap is 0.
// Backpr. : hdr and payload are held stable until their ready; no data is dropped or skipped.
//
// Ports:
//   clk, rst_n              clock and async active-low reset
//   enable                  level, 1 = keep generating frames
//   frame_limit             frames per run (0 = unlimited), latched when a run starts
//   gap_cycles              idle cycles inserted after each tlast, sampled at tlast
//   m_eth_hdr_*             header handshake plus constant MAC/type fields
//   m_eth_payload_axis_*    AXI-stream payload; tdata is the global beat counter
//   busy, done              status; done marks a completed limited run until enable drops
//   frame_count, beat_count free-running debug counters (wrap silently)
module test_sender #(
  parameter int          LENGTH      = 512,
  parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_00,
  parameter logic [47:0] DST_MAC     = 48'h02_00_00_00_00_00,
  parameter logic [15:0] ETH_TYPE    = 16'h88B5,
  parameter int          DATA_WIDTH  = 8,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int          KEEP_WIDTH  = (DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  enable,
  input  logic [31:0]           frame_limit,
  input  logic [15:0]           gap_cycles,

  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,

  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,

  output logic                  busy,
  output logic                  done,
  output logic [31:0]           frame_count,
  output logic [31:0]           beat_count
);

  // Index of the final payload beat within a frame.
  localparam logic [15:0] LAST_BEAT = 16'(LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_GAP
  } state_t;

  state_t      state;
  logic        hdr_valid;
  logic        tvalid;
  logic        tlast;
  logic [15:0] frame_beat;
  logic [31:0] sent_in_run;
  logic [31:0] limit;
  logic [15:0] gap_cnt;

  // Header fields never change, so they are trivially stable under backpressure.
  assign m_eth_dest_mac = DST_MAC;
  assign m_eth_src_mac  = LOCAL_MAC;
  assign m_eth_type     = ETH_TYPE;

  assign m_eth_hdr_valid           = hdr_valid;
  assign m_eth_payload_axis_tvalid = tvalid;
  assign m_eth_payload_axis_tlast  = tlast;
  assign m_eth_payload_axis_tuser  = 1'b0;

  // Payload is the global beat counter; it only moves on a fire, so it is
  // stable while the sink stalls and continues across frame boundaries.
  generate
    if (DATA_WIDTH > 32) begin : g_wide_data
      assign m_eth_payload_axis_tdata = {{(DATA_WIDTH-32){1'b0}}, beat_count};
    end else begin : g_narrow_data
      assign m_eth_payload_axis_tdata = beat_count[DATA_WIDTH-1:0];
    end
  endgenerate

  // Every beat is full; with a single-byte bus the keep lane is ignored downstream.
  generate
    if (KEEP_ENABLE) begin : g_keep
      assign m_eth_payload_axis_tkeep = {KEEP_WIDTH{1'b1}};
    end else begin : g_no_keep
      assign m_eth_payload_axis_tkeep = {KEEP_WIDTH{1'b1}};
    end
  endgenerate

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      hdr_valid   <= 1'b0;
      tvalid      <= 1'b0;
      tlast       <= 1'b0;
      done        <= 1'b0;
      frame_count <= 32'd0;
      beat_count  <= 32'd0;
      frame_beat  <= 16'd0;
      sent_in_run <= 32'd0;
      limit       <= 32'd0;
      gap_cnt     <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // done is sticky until enable drops, so a new run needs a fresh 0->1 edge.
          if (!enable) begin
            done <= 1'b0;
          end
          if (enable && !done) begin
            limit       <= frame_limit;
            sent_in_run <= 32'd0;
            hdr_valid   <= 1'b1;
            state       <= S_HDR;
          end
        end

        S_HDR: begin
          // Once the header is offered the frame is committed, enable or not.
          if (m_eth_hdr_ready) begin
            hdr_valid  <= 1'b0;
            tvalid     <= 1'b1;
            tlast      <= (LAST_BEAT == 16'd0);
            frame_beat <= 16'd0;
            state      <= S_PAYLOAD;
          end
        end

        S_PAYLOAD: begin
          if (m_eth_payload_axis_tready) begin
            beat_count <= beat_count + 32'd1;
            if (tlast) begin
              frame_beat  <= 16'd0;
              frame_count <= frame_count + 32'd1;
              sent_in_run <= sent_in_run + 32'd1;
              gap_cnt     <= gap_cycles;
              tvalid      <= 1'b0;
              tlast       <= 1'b0;
              if ((limit != 32'd0) && ((sent_in_run + 32'd1) == limit)) begin
                done  <= 1'b1;
                state <= S_IDLE;
              end else if (gap_cycles == 16'd0) begin
                // No gap: header goes out the very next cycle unless we are stopping.
                if (enable) begin
                  hdr_valid <= 1'b1;
                  state     <= S_HDR;
                end else begin
                  state <= S_IDLE;
                end
              end else begin
                state <= S_GAP;
              end
            end else begin
              frame_beat <= frame_beat + 16'd1;
              // Look one beat ahead so tlast is registered alongside the beat it marks.
              tlast      <= ((frame_beat + 16'd1) == LAST_BEAT);
            end
          end
        end

        S_GAP: begin
          // gap_cnt enters at gap_cycles and we leave while it reads 1,
          // giving exactly gap_cycles cycles with neither valid asserted.
          gap_cnt <= gap_cnt - 16'd1;
          if (gap_cnt <= 16'd1) begin
            if (enable) begin
              hdr_valid <= 1'b1;
              state     <= S_HDR;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          hdr_valid <= 1'b0;
          tvalid    <= 1'b0;
          tlast     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_sender.sv
module tb_test_sender;

  localparam int LEN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] frame_limit = 32'd0;
  logic [15:0] gap_cycles = 16'd0;
  logic        hdr_valid;
  logic        hdr_ready = 1'b1;
  logic [47:0] dmac;
  logic [47:0] smac;
  logic [15:0] etype;
  logic [7:0]  tdata;
  logic [0:0]  tkeep;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
  logic        tuser;
  logic        busy;
  logic        done;
  logic [31:0] frame_count;
  logic [31:0] beat_count;

  test_sender #(
    .LENGTH     (LEN),
    .LOCAL_MAC  (48'h02_11_22_33_44_55),
    .DST_MAC    (48'h02_AA_BB_CC_DD_EE),
    .ETH_TYPE   (16'h88B5),
    .DATA_WIDTH (8)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .enable                    (enable),
    .frame_limit               (frame_limit),
    .gap_cycles                (gap_cycles),
    .m_eth_hdr_valid           (hdr_valid),
    .m_eth_hdr_ready           (hdr_ready),
    .m_eth_dest_mac            (dmac),
    .m_eth_src_mac             (smac),
    .m_eth_type                (etype),
    .m_eth_payload_axis_tdata  (tdata),
    .m_eth_payload_axis_tkeep  (tkeep),
    .m_eth_payload_axis_tvalid (tvalid),
    .m_eth_payload_axis_tready (tready),
    .m_eth_payload_axis_tlast  (tlast),
    .m_eth_payload_axis_tuser  (tuser),
    .busy                      (busy),
    .done                      (done),
    .frame_count               (frame_count),
    .beat_count                (beat_count)
  );

  always #4 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream monitor: sampled on the falling edge, where inputs and outputs are
  // settled; anything with valid & ready here fires on the next rising edge.
  logic [31:0] exp_data = 32'd0;
  int          exp_beat = 0;
  int          hdr_fires = 0;
  int          idle_run = 0;
  int          last_gap = -1;
  bit          gap_arm = 1'b0;
  bit          prev_pstall = 1'b0;
  bit          prev_hstall = 1'b0;
  logic [7:0]  prev_tdata = 8'd0;
  logic        prev_tlast = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_data    = 32'd0;
      exp_beat    = 0;
      prev_pstall = 1'b0;
      prev_hstall = 1'b0;
      gap_arm     = 1'b0;
      idle_run    = 0;
    end else begin
      check("valid_exclusive", hdr_valid & tvalid, 0);
      if (prev_pstall) begin
        check("tvalid_held", tvalid, 1);
        check("tdata_stable", tdata, prev_tdata);
        check("tlast_stable", tlast, prev_tlast);
      end
      if (prev_hstall) check("hdr_valid_held", hdr_valid, 1);
      if (gap_arm) begin
        if (hdr_valid) begin
          last_gap = idle_run;
          gap_arm  = 1'b0;
        end else if (!tvalid) begin
          idle_run++;
        end
      end
      if (hdr_valid && hdr_ready) begin
        hdr_fires++;
        check("hdr_dest_mac", dmac, 48'h02_AA_BB_CC_DD_EE);
        check("hdr_src_mac", smac, 48'h02_11_22_33_44_55);
        check("hdr_type", etype, 16'h88B5);
      end
      if (tvalid && tready) begin
        check("tdata_seq", tdata, exp_data[7:0]);
        check("tlast_pos", tlast, (exp_beat == LEN-1));
        exp_data = exp_data + 32'd1;
        exp_beat = (exp_beat == LEN-1) ? 0 : exp_beat + 1;
        if (tlast) begin
          gap_arm  = 1'b1;
          idle_run = 0;
        end
      end
      prev_pstall = tvalid & ~tready;
      prev_hstall = hdr_valid & ~hdr_ready;
      prev_tdata  = tdata;
      prev_tlast  = tlast;
    end
  end

  initial begin
    bit ok;

    // Reset values
    step();
    step();
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_beat_count", beat_count, 0);
    check("rst_tdata", tdata, 0);
    check("tkeep_ones", tkeep, 1);
    check("tuser_zero", tuser, 0);

    rst_n = 1'b1;
    step();

    // Two-frame limited run, gap 0, readies held high
    frame_limit = 32'd2;
    gap_cycles  = 16'd0;
    enable      = 1'b1;
    step();
    check("start_latency_hdr_valid", hdr_valid, 1);
    check("start_busy", busy, 1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin ok = 1'b1; break; end
      step();
    end
    check("a_done_timeout", ok, 1);
    check("a_frame_count", frame_count, 2);
    check("a_beat_count", beat_count, 8);
    check("a_busy", busy, 0);
    check("a_monitor_beats", exp_data, 8);
    check("a_hdr_fires", hdr_fires, 2);
    check("a_back_to_back_gap", last_gap, 0);
    step(); step(); step();
    check("a_no_restart_busy", busy, 0);
    check("a_done_held", done, 1);
    enable = 1'b0;
    step();
    check("a_done_cleared", done, 0);

    // Three frames with a 5-cycle gap
    frame_limit = 32'd3;
    gap_cycles  = 16'd5;
    enable      = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done) begin ok = 1'b1; break; end
    end
    check("b_done_timeout", ok, 1);
    check("b_frame_count", frame_count, 5);
    check("b_beat_count", beat_count, 20);
    check("b_gap_len", last_gap, 5);
    check("b_hdr_fires", hdr_fires, 5);
    enable = 1'b0;
    step();

    // Random backpressure on both readies, five frames, gap 1
    frame_limit = 32'd5;
    gap_cycles  = 16'd1;
    enable      = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      hdr_ready = 1'($urandom_range(0, 1));
      tready    = 1'($urandom_range(0, 1));
      step();
      if (done) begin ok = 1'b1; break; end
    end
    hdr_ready = 1'b1;
    tready    = 1'b1;
    check("c_done_timeout", ok, 1);
    check("c_frame_count", frame_count, 10);
    check("c_beat_count", beat_count, 40);
    check("c_monitor_beats", exp_data, 40);
    enable = 1'b0;
    step();

    // Unlimited run, enable dropped at beat 2 of a frame: frame must complete
    frame_limit = 32'd0;
    gap_cycles  = 16'd0;
    enable      = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tvalid && beat_count == 32'd42) begin ok = 1'b1; break; end
    end
    check("d_reach_beat2", ok, 1);
    enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (!busy) begin ok = 1'b1; break; end
    end
    check("d_idle_timeout", ok, 1);
    check("d_frame_count", frame_count, 11);
    check("d_beat_count", beat_count, 44);
    check("d_done", done, 0);
    step(); step();
    check("d_stays_idle", busy, 0);

    // Async reset mid-payload, then a fresh frame from zero
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tvalid && beat_count == 32'd46) begin ok = 1'b1; break; end
    end
    check("e_reach_mid", ok, 1);
    rst_n = 1'b0;
    #1;
    check("e_rst_tvalid", tvalid, 0);
    check("e_rst_hdr_valid", hdr_valid, 0);
    check("e_rst_tlast", tlast, 0);
    check("e_rst_busy", busy, 0);
    check("e_rst_beat_count", beat_count, 0);
    check("e_rst_frame_count", frame_count, 0);
    check("e_rst_tdata", tdata, 0);
    step();
    step();
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tvalid) begin ok = 1'b1; break; end
    end
    check("e_restart_timeout", ok, 1);
    check("e_first_tdata", tdata, 0);
    enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!busy) begin ok = 1'b1; break; end
    end
    check("e_idle_timeout", ok, 1);
    check("e_frame_count", frame_count, 1);
    check("e_beat_count", beat_count, 4);
    check("e_monitor_beats", exp_data, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
